hann_framer: RTL and testbench
==============================

HANN_FRAMER -- requirements
Module: hann_framer

Interface
REQ-001 Parameter DATA_W, default 12: ADC sample width.
REQ-002 Parameter COEFF_W, default 12: window coefficient width, unsigned, scaled by 2^COEFF_W.
REQ-003 Parameter OUT_W, default 16: output sample width; legal range is OUT_W <= DATA_W+COEFF_W.
REQ-004 Parameter FRAME_LEN, default 2048: samples per frame; power of two, >= 8.
REQ-005 Parameter HOP, default 1024: new samples between frame starts; legal range 1..FRAME_LEN.
REQ-006 Parameter OFFSET_BIN, default 1: 1 means adc_data is offset-binary and its MSB is inverted on write; 0 means adc_data is two's complement.
REQ-007 Design has one clock; reset is asynchronous and active-low.
REQ-008 clk_100mhz  in  1  system clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 sample_trigger  in  1  single-cycle strobe qualifying adc_data.
REQ-011 adc_data  in  DATA_W  ADC sample.
REQ-012 coeff_addr  out  log2(FRAME_LEN)  address to external synchronous coefficient ROM.
REQ-013 coeff_data  in  COEFF_W  ROM data, valid exactly 1 cycle after coeff_addr.
REQ-014 fft_data  out  OUT_W  windowed sample, two's complement.
REQ-015 fft_valid  out  1  fft_data, fft_last and fft_index are valid.
REQ-016 fft_ready  in  1  downstream accepts the beat.
REQ-017 fft_last  out  1  marks the final beat of a frame.
REQ-018 fft_index  out  log2(FRAME_LEN)  beat position within the frame.
REQ-019 frame_drop  out  1  one-cycle pulse when a due frame is skipped.
REQ-020 drop_count  out  16  saturating count of dropped frames.
REQ-021 state  out  2  debug: FILL=0, IDLE=1, EMIT=2.

Function
REQ-022 The block SHALL hold samples in an internal circular buffer of depth 2*FRAME_LEN; each sample_trigger writes one sample and advances the write pointer modulo 2*FRAME_LEN.
REQ-023 FILL: after the FRAME_LEN-th trigger since reset, the block SHALL enter EMIT on the next cycle, with frame start = oldest stored sample.
REQ-024 IDLE: a hop counter SHALL count triggers since the last frame start; on reaching HOP it SHALL reset to 0 and the block SHALL enter EMIT with frame start = previous start + HOP (mod depth).
REQ-025 EMIT SHALL read samples start..start+FRAME_LEN-1 in order, with coeff_addr equal to the in-frame index.
REQ-026 Each output SHALL equal the top OUT_W bits of the signed (DATA_W+COEFF_W)-bit product of sample × coefficient, truncated by floor.
REQ-027 The first fft_valid of a frame SHALL assert no later than 4 cycles after entry to EMIT.
REQ-028 Handshake: a beat transfers when fft_valid && fft_ready; while fft_valid && !fft_ready, fft_data, fft_last and fft_index SHALL hold stable.
REQ-029 fft_valid SHALL NOT deassert until the beat is accepted.
REQ-030 At fft_ready=1 continuously, throughput SHALL be 1 beat per cycle.
REQ-031 fft_index SHALL run 0..FRAME_LEN-1; fft_last SHALL be 1 only at index FRAME_LEN-1.
REQ-032 After the last beat is accepted, the block SHALL go to IDLE, or directly to EMIT if a hop completed on that same cycle (not a drop).
REQ-033 If the hop counter reaches HOP while in EMIT before the last-beat handshake, that frame SHALL be skipped: frame_drop pulses 1 cycle, drop_count increments (saturating at 0xFFFF), the hop counter restarts, and the frame start advances by HOP.
REQ-034 Sample writes SHALL continue in every state; data integrity is guaranteed only if EMIT completes within FRAME_LEN triggers.

Reset
REQ-035 rst_n low SHALL immediately clear fft_valid, fft_last, frame_drop, fft_data, fft_index, coeff_addr, drop_count, the pointers and the hop counter, and set state=FILL.
REQ-036 Reset asserted mid-frame SHALL abandon the frame; after release, FRAME_LEN new triggers are required before the next output.

Verification (DATA_W=12, COEFF_W=12, OUT_W=16, FRAME_LEN=8, HOP=4, OFFSET_BIN=1)
REQ-037 Ramp: adc_data=0x800+i for i=0..7, coeff=0xFFF, fft_ready=1 -> fft_data = 0,15,31,47,63,79,95,111; fft_last only on beat 7.
REQ-038 Overlap: 4 further triggers (i=8..11) -> second frame carries samples 4..11, starting with fft_data=63.
REQ-039 Backpressure: fft_ready toggled pseudo-randomly -> no beat lost or duplicated, and outputs stable while stalled.
REQ-040 Drop: fft_ready=0 held through 4 extra triggers -> one frame_drop pulse and drop_count=1.
REQ-041 Negative full-scale: adc_data=0x000, coeff=0x800 -> fft_data=0xC000.
REQ-042 Reset: rst_n low during beat 3 -> fft_valid=0 in the same cycle, state=FILL, and no output until 8 new triggers.

Source files
------------

// File: rtl/hann_framer.sv
// Overlapping-frame windowing front end: buffers ADC samples in a circular store,
// emits FRAME_LEN-sample frames every HOP triggers, multiplied by an external ROM window.
module hann_framer #(
    parameter int DATA_W     = 12,
    parameter int COEFF_W    = 12,
    parameter int OUT_W      = 16,
    parameter int FRAME_LEN  = 2048,
    parameter int HOP        = 1024,
    parameter int OFFSET_BIN = 1
) (
    input  logic                         clk_100mhz,
    input  logic                         rst_n,
    input  logic                         sample_trigger,
    input  logic [DATA_W-1:0]            adc_data,
    output logic [$clog2(FRAME_LEN)-1:0] coeff_addr,
    input  logic [COEFF_W-1:0]           coeff_data,
    output logic [OUT_W-1:0]             fft_data,
    output logic                         fft_valid,
    input  logic                         fft_ready,
    output logic                         fft_last,
    output logic [$clog2(FRAME_LEN)-1:0] fft_index,
    output logic                         frame_drop,
    output logic [15:0]                  drop_count,
    output logic [1:0]                   state
);
    localparam int AW     = $clog2(FRAME_LEN);
    localparam int PW     = AW + 1;
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int SHIFT  = PROD_W - OUT_W;
    localparam logic [DATA_W-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {FILL = 2'd0, IDLE = 2'd1, EMIT = 2'd2} state_t;
    state_t cur_state, nxt_state;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];
    logic [PW-1:0]     wr_ptr, start_ptr, base_ptr, rd_ptr, hop_cnt, new_start;
    logic [AW-1:0]     iss_idx, p2_idx;
    logic              iss_active, p1_v, p2_v;
    logic signed [DATA_W-1:0] sample_q;
    logic signed [PROD_W-1:0] prod, prod_sh;

    logic [OUT_W-1:0]  f_data [4];
    logic [AW-1:0]     f_idx  [4];
    logic              f_last [4];
    logic [1:0]        f_wptr, f_rptr;
    logic [2:0]        f_cnt;
    logic [3:0]        occ;
    logic              fill_done, hop_done, last_acc, load_frame, drop, issue, pop;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) cur_state <= FILL;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            FILL:    if (fill_done) nxt_state = EMIT;
            IDLE:    if (hop_done)  nxt_state = EMIT;
            EMIT:    if (last_acc)  nxt_state = hop_done ? EMIT : IDLE;
            default: nxt_state = FILL;
        endcase
    end

    always_comb begin
        state      = cur_state;
        fft_valid  = (f_cnt != 3'd0);
        fft_data   = f_data[f_rptr];
        fft_index  = f_idx[f_rptr];
        fft_last   = f_last[f_rptr];
        pop        = fft_valid && fft_ready;
        fill_done  = (cur_state == FILL) && sample_trigger && (wr_ptr == PW'(FRAME_LEN - 1));
        hop_done   = (cur_state != FILL) && sample_trigger && (hop_cnt == PW'(HOP - 1));
        last_acc   = pop && fft_last;
        load_frame = fill_done || ((cur_state == IDLE) && hop_done)
                   || ((cur_state == EMIT) && last_acc && hop_done);
        drop       = (cur_state == EMIT) && hop_done && !last_acc;
        new_start  = (cur_state == FILL) ? wr_ptr - PW'(FRAME_LEN - 1) : start_ptr + PW'(HOP);
        // Reads are issued only when the 4-entry output FIFO can absorb everything in flight,
        // so the ROM/buffer pipeline never has to stall.
        occ        = 4'(f_cnt) + 4'(p1_v) + 4'(p2_v);
        issue      = (cur_state == EMIT) && iss_active && (occ < 4'd4);
    end

    always_comb begin
        prod    = sample_q * $signed({1'b0, coeff_data});
        prod_sh = prod >>> SHIFT;
    end

    always_ff @(posedge clk_100mhz) begin
        if (sample_trigger) mem[wr_ptr] <= adc_data ^ MSB_FLIP;
        sample_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            start_ptr  <= '0;
            base_ptr   <= '0;
            rd_ptr     <= '0;
            hop_cnt    <= '0;
            iss_idx    <= '0;
            iss_active <= 1'b0;
            coeff_addr <= '0;
            p1_v       <= 1'b0;
            p2_v       <= 1'b0;
            p2_idx     <= '0;
            f_wptr     <= '0;
            f_rptr     <= '0;
            f_cnt      <= '0;
            frame_drop <= 1'b0;
            drop_count <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                f_data[i] <= '0;
                f_idx[i]  <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            frame_drop <= drop;
            if (sample_trigger) wr_ptr <= wr_ptr + 1'b1;
            if (hop_done)
                hop_cnt <= '0;
            else if (sample_trigger && cur_state != FILL)
                hop_cnt <= hop_cnt + 1'b1;
            // A skipped frame only moves the hop origin; the frame being emitted keeps base_ptr.
            if (load_frame) begin
                start_ptr  <= new_start;
                base_ptr   <= new_start;
                iss_idx    <= '0;
                iss_active <= 1'b1;
            end else if (drop) begin
                start_ptr  <= new_start;
            end
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            p1_v <= issue;
            if (issue) begin
                coeff_addr <= iss_idx;
                rd_ptr     <= base_ptr + PW'(iss_idx);
                iss_idx    <= iss_idx + 1'b1;
                if (iss_idx == AW'(FRAME_LEN - 1)) iss_active <= 1'b0;
            end
            p2_v   <= p1_v;
            p2_idx <= coeff_addr;
            if (p2_v) begin
                f_data[f_wptr] <= OUT_W'(prod_sh);
                f_idx[f_wptr]  <= p2_idx;
                f_last[f_wptr] <= (p2_idx == AW'(FRAME_LEN - 1));
                f_wptr         <= f_wptr + 1'b1;
            end
            if (pop) f_rptr <= f_rptr + 1'b1;
            f_cnt <= f_cnt + 3'(p2_v) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_hann_framer.sv
// Scoreboard bench for hann_framer (FRAME_LEN=8, HOP=4): directed frames with
// hand-computed windowed outputs, backpressure, drop, negative full scale and mid-frame reset.
module tb_hann_framer;
    logic        clk = 1'b0, rst_n = 1'b1, trig = 1'b0, fft_ready = 1'b0;
    logic [11:0] adc = '0, coeff_data = '0;
    logic [2:0]  coeff_addr, fft_index;
    logic [15:0] fft_data, drop_count;
    logic        fft_valid, fft_last, frame_drop;
    logic [1:0]  state;

    hann_framer #(.DATA_W(12), .COEFF_W(12), .OUT_W(16), .FRAME_LEN(8), .HOP(4), .OFFSET_BIN(1)) dut (
        .clk_100mhz(clk), .rst_n(rst_n), .sample_trigger(trig), .adc_data(adc),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data), .fft_data(fft_data),
        .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_last(fft_last),
        .fft_index(fft_index), .frame_drop(frame_drop), .drop_count(drop_count), .state(state));

    always #5 clk = ~clk;

    logic [11:0] rom [8];
    always @(posedge clk) coeff_data <= rom[coeff_addr];

    typedef struct packed { logic [15:0] data; logic [2:0] idx; logic last; } beat_t;
    beat_t exp_q[$];
    beat_t exp_b, prev_beat;
    int    n_vec = 0, n_err = 0, drop_pulses = 0, valid_seen = 0, lat = 0;
    bit    rand_ready = 0, prev_stall = 0, armed = 0;
    logic [1:0] prev_state = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold-while-stalled.
    always @(negedge clk) begin
        if (frame_drop) drop_pulses++;
        if (fft_valid) valid_seen++;
        if (prev_stall) begin
            check("stall_valid", fft_valid, 1);
            check("stall_data", fft_data, prev_beat.data);
            check("stall_index", fft_index, prev_beat.idx);
            check("stall_last", fft_last, prev_beat.last);
        end
        if (fft_valid && fft_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h idx %0d, expected no beat", fft_data, fft_index);
            end else begin
                exp_b = exp_q.pop_front();
                check("beat_data", fft_data, exp_b.data);
                check("beat_index", fft_index, exp_b.idx);
                check("beat_last", fft_last, exp_b.last);
            end
        end
        prev_stall = fft_valid && !fft_ready;
        prev_beat  = '{fft_data, fft_index, fft_last};
    end

    // First beat of a frame must follow entry to EMIT within 4 cycles.
    always @(negedge clk) begin
        if (state == 2'd2 && prev_state != 2'd2) begin
            armed = 1;
            lat   = 0;
        end
        if (armed) begin
            if (fft_valid) begin
                check("first_valid_latency_le4", (lat <= 4), 1);
                armed = 0;
            end else begin
                lat++;
                if (lat > 8) begin
                    check("first_valid_latency_le4", 0, 1);
                    armed = 0;
                end
            end
        end
        prev_state = state;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) fft_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [11:0] value, input int gap);
        tick();
        trig = 1'b1;
        adc  = value;
        tick();
        trig = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push_frame(input int vals [8]);
        for (int k = 0; k < 8; k++) exp_q.push_back('{16'(vals[k]), 3'(k), (k == 7)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic set_rom(input logic [11:0] v);
        for (int k = 0; k < 8; k++) rom[k] = v;
    endtask

    initial begin
        int ramp [8] = '{0, 15, 31, 47, 63, 79, 95, 111};
        int f2   [8] = '{63, 79, 95, 111, 127, 143, 159, 175};
        int bp   [8] = '{8, 18, 30, 44, 60, 78, 98, 120};
        int dp   [8] = '{191, 207, 223, 239, 255, 271, 287, 303};
        int neg  [8] = '{160, 168, 176, 184, 16'hC000, 16'hC000, 16'hC000, 16'hC000};
        bit found = 0;

        set_rom(12'hFFF);
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_valid", fft_valid, 0);
        check("rst_coeff_addr", coeff_addr, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("rst_data", fft_data, 0);
        rst_n = 1'b1;
        tick();

        // Ramp: first frame after FILL
        fft_ready = 1'b1;
        push_frame(ramp);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("fill_state", state, 0);
            send(12'(12'h800 + i), 3);
        end
        wait_drain("ramp_drained", 100);
        tick();
        check("idle_after_ramp", state, 1);

        // Overlap: HOP further triggers start a frame at sample 4
        push_frame(f2);
        for (int i = 8; i < 12; i++) send(12'(12'h800 + i), 3);
        wait_drain("overlap_drained", 100);
        tick();
        check("idle_after_overlap", state, 1);

        // Backpressure with a varying window
        for (int k = 0; k < 8; k++) rom[k] = 12'((k + 1) << 8);
        push_frame(bp);
        rand_ready = 1;
        for (int i = 12; i < 16; i++) send(12'(12'h800 + i), 3);
        wait_drain("backpressure_drained", 400);
        rand_ready = 0;
        fft_ready  = 1'b1;
        tick();
        check("idle_after_backpressure", state, 1);

        // Drop: stalled frame while a further hop completes
        set_rom(12'hFFF);
        fft_ready   = 1'b0;
        push_frame(dp);
        drop_pulses = 0;
        for (int i = 16; i < 20; i++) send(12'(12'h800 + i), 3);
        check("emit_while_stalled", state, 2);
        for (int i = 20; i < 24; i++) send(12'(12'h800 + i), 3);
        tick();
        check("drop_pulses", drop_pulses, 1);
        check("drop_count", drop_count, 1);
        check("stalled_index", fft_index, 0);
        fft_ready = 1'b1;
        wait_drain("drop_frame_drained", 100);
        tick();
        check("idle_after_drop", state, 1);

        // Negative full scale in second half of next frame (samples 20..27)
        set_rom(12'h800);
        push_frame(neg);
        for (int i = 0; i < 4; i++) send(12'h000, 3);
        wait_drain("negative_drained", 100);
        tick();

        // Reset during beat 3
        set_rom(12'hFFF);
        for (int k = 0; k < 3; k++) exp_q.push_back('{16'h8008, 3'(k), 1'b0});
        for (int i = 0; i < 4; i++) send(12'h800, (i == 3) ? 0 : 3);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fft_valid && fft_index == 3'd3) begin
                found = 1;
                break;
            end
        end
        check("reached_beat3", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", fft_valid, 0);
        check("midrst_state", state, 0);
        check("midrst_index", fft_index, 0);
        check("midrst_drop_count", drop_count, 0);
        check("midrst_beats_consumed", exp_q.size(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 7; i++) send(12'(12'h800 + i), 3);
        repeat (10) tick();
        check("quiet_after_reset", valid_seen, 0);
        check("fill_after_reset", state, 0);
        push_frame(ramp);
        send(12'h807, 0);
        wait_drain("post_reset_drained", 100);
        tick();
        check("idle_after_post_reset", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
